instr_fetch: RTL

- Fetch stage directly upstream of the control unit's decode/execute logic.
- Owns the XM-23 program counter (R7 view).
- Each cycle it can, it issues a word read to memory over a req/ack handshake, latches the returned word as the instruction, and presents it with its own PC to decode through a valid/ready handshake.
- Accepts PC redirects (branch, jump, exception vector) from execute; flushes or discards any in-flight fetch.

---
 rtl/xm23_pkg.sv | 29 ++
 rtl/instr_fetch.sv | 116 +++++++++++
 2 files changed

// File: rtl/xm23_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : xm23_pkg                                                   |
// | Shared XM-23 types and constants for the fetch stage, register file |
// | and control unit.                                                    |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package xm23_pkg;

  // Fetch stage sequencing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;

  // Bytes per instruction word.
  localparam int PC_INC = 2;

  // Memory read/write encoding: read is 0.
  localparam logic MEM_READ = 1'b0;

  // Register-file index that aliases the program counter.
  localparam logic [2:0] PC_REG = 3'd7;

endpackage
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : instr_fetch                                                |
// | XM-23 fetch stage: owns the PC, reads instruction words over a      |
// | req/ack port and hands them to decode over valid/ready. Redirects   |
// | from execute squash any in-flight fetch.                             |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module instr_fetch
  import xm23_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rw,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_fault
);

  fetch_state_t state;

  // The fetch port only ever reads.
  assign mem_rw = MEM_READ;

  // Fetch sequencer, PC register and IR latch. A redirect overrides all
  // normal sequencing; an outstanding request is still carried to its ack
  // (via DRAIN) so the memory handshake is never broken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (pc_load) begin
      pc          <= pc_load_val;
      ir_valid    <= 1'b0;
      fetch_fault <= 1'b0;
      case (state)
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else begin
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en) begin
            if (pc[0]) begin
              fetch_fault <= 1'b1;
              state       <= FAULT;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= pc;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            ir       <= mem_rdata;
            ir_pc    <= pc;
            pc       <= pc + ADDR_W'(PC_INC);
            ir_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            ir_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        FAULT: state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
